// File: rtl/gtxe2_chnl_tx_oob_pkg.sv
// gtxe2_chnl_tx_oob_defs: state/type encodings and OOB timing defaults.
// The timing defaults are shared with the RX OOB detector.
package gtxe2_chnl_tx_oob_defs;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd1, ST_GAP = 2'd2} state_e;
    typedef enum logic [1:0] {OOB_INIT = 2'd0, OOB_WAKE = 2'd1, OOB_SAS = 2'd2} oob_e;

    localparam int          DEF_WIDTH         = 20;
    localparam logic [19:0] DEF_BURST_PATTERN = 20'b1010000011_0101111100;
    localparam int          DEF_BURST_COUNT   = 6;
    localparam int          DEF_BURST_LEN     = 8;
    localparam int          DEF_GAP_INIT      = 24;
    localparam int          DEF_GAP_WAKE      = 8;
    localparam int          DEF_GAP_SAS       = 72;

    function automatic int clogb2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > d ? m : d;
    endfunction

endpackage

// File: rtl/gtxe2_chnl_tx_oob_timer.sv
// gtxe2_chnl_tx_oob_timer: loadable down-counter that stops at zero.
module gtxe2_chnl_tx_oob_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign zero = cnt_q == '0;

endmodule

// File: rtl/gtxe2_chnl_tx_oob.sv
// gtxe2_chnl_tx_oob: TX OOB burst/gap sequencer (COMINIT/COMWAKE/COMSAS)
// with pass-through and electrical-idle forcing outside a sequence.
module gtxe2_chnl_tx_oob
    import gtxe2_chnl_tx_oob_defs::*;
#(
    parameter int               width         = DEF_WIDTH,
    parameter logic [width-1:0] BURST_PATTERN = DEF_BURST_PATTERN,
    parameter int               BURST_COUNT   = DEF_BURST_COUNT,
    parameter int               BURST_LEN     = DEF_BURST_LEN,
    parameter int               GAP_INIT      = DEF_GAP_INIT,
    parameter int               GAP_WAKE      = DEF_GAP_WAKE,
    parameter int               GAP_SAS       = DEF_GAP_SAS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] indata,
    output logic [width-1:0] outdata,
    output logic             outelecidle,
    input  logic             TXELECIDLE,
    input  logic             TXCOMINIT,
    input  logic             TXCOMWAKE,
    input  logic             TXCOMSAS,
    output logic             TXCOMFINISH
);

    localparam int CW = clogb2(max4(BURST_LEN, GAP_INIT, GAP_WAKE, GAP_SAS) + 1);
    localparam int BW = clogb2(BURST_COUNT + 1);

    state_e           state_q, state_d;
    oob_e             req_type;
    logic [width-1:0] out_q, out_d;
    logic             eidle_q, eidle_d, fin_q, fin_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [CW-1:0]    gap_q, gap_d, tmr_val;
    logic             tmr_load, tmr_zero, req;

    always_comb begin
        req      = TXCOMINIT | TXCOMWAKE | TXCOMSAS;
        req_type = TXCOMINIT ? OOB_INIT : TXCOMWAKE ? OOB_WAKE : OOB_SAS;
        state_d  = state_q;
        gap_d    = gap_q;
        case (state_q)
            ST_IDLE:  state_d = (TXELECIDLE && req) ? ST_BURST : ST_IDLE;
            ST_BURST: state_d = !TXELECIDLE ? ST_IDLE : tmr_zero ? ST_GAP : ST_BURST;
            ST_GAP:   state_d = !TXELECIDLE ? ST_IDLE : !tmr_zero ? ST_GAP :
                                bcnt_q == '0 ? ST_IDLE : ST_BURST;
            default:  state_d = ST_IDLE;
        endcase
        // gap_q holds gap-1 so it can be loaded straight into the timer
        if (state_q == ST_IDLE && state_d == ST_BURST)
            gap_d = req_type == OOB_INIT ? CW'(GAP_INIT - 1) :
                    req_type == OOB_WAKE ? CW'(GAP_WAKE - 1) : CW'(GAP_SAS - 1);
        bcnt_d   = (state_q == ST_IDLE && state_d == ST_BURST) ? BW'(BURST_COUNT) :
                   (state_q == ST_BURST && state_d == ST_GAP)  ? bcnt_q - BW'(1) :
                   (state_d == ST_IDLE)                        ? '0 : bcnt_q;
        fin_d    = state_q == ST_GAP && TXELECIDLE && tmr_zero && bcnt_q == '0;
        out_d    = state_d == ST_BURST ? BURST_PATTERN :
                   (state_d == ST_GAP || TXELECIDLE) ? '0 : indata;
        eidle_d  = state_d == ST_BURST ? 1'b0 : state_d == ST_GAP ? 1'b1 : TXELECIDLE;
        tmr_load = state_d != state_q;
        tmr_val  = state_d == ST_BURST ? CW'(BURST_LEN - 1) : state_d == ST_GAP ? gap_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            eidle_q <= 1'b1;
            fin_q   <= 1'b0;
            bcnt_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            eidle_q <= eidle_d;
            fin_q   <= fin_d;
            bcnt_q  <= bcnt_d;
            gap_q   <= gap_d;
        end

    gtxe2_chnl_tx_oob_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (state_q != ST_IDLE),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign outdata     = out_q;
    assign outelecidle = eidle_q;
    assign TXCOMFINISH = fin_q;

endmodule

// File: tb/tb_gtxe2_chnl_tx_oob.sv
// tb_gtxe2_chnl_tx_oob: directed test-plan scenarios plus random traffic,
// checked every cycle against a cycle-offset arithmetic model.
module tb_gtxe2_chnl_tx_oob;

    localparam int          BC  = 6;
    localparam int          BL  = 8;
    localparam logic [19:0] PAT = 20'b1010000011_0101111100;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic [19:0] indata = '0;
    logic        eidle_in = 1'b1, ci = 1'b0, cw = 1'b0, cs = 1'b0;
    logic [19:0] outdata;
    logic        outelecidle, fin;

    int checks = 0, errors = 0;
    bit act = 0;
    int t = 0, per = 1;
    logic [19:0] e_data;
    logic        e_eidle, e_fin;

    gtxe2_chnl_tx_oob dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .indata      (indata),
        .outdata     (outdata),
        .outelecidle (outelecidle),
        .TXELECIDLE  (eidle_in),
        .TXCOMINIT   (ci),
        .TXCOMWAKE   (cw),
        .TXCOMSAS    (cs),
        .TXCOMFINISH (fin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // t counts edges since acceptance; each burst+gap period is BL+gap cycles
    task automatic model();
        e_fin = 1'b0;
        if (act && eidle_in) begin
            t++;
            if (t == BC * per) begin
                act = 0; e_data = '0; e_eidle = 1'b1; e_fin = 1'b1;
            end else begin
                e_data  = (t % per) < BL ? PAT : '0;
                e_eidle = (t % per) >= BL;
            end
        end else if (!act && eidle_in && (ci | cw | cs)) begin
            act = 1; t = 0;
            per = BL + (ci ? 24 : cw ? 8 : 72);
            e_data = PAT; e_eidle = 1'b0;
        end else begin
            act = 0;
            e_data  = eidle_in ? '0 : indata;
            e_eidle = eidle_in;
        end
    endtask

    task automatic cyc(input bit e, input bit i, input bit w, input bit s, input logic [19:0] d);
        eidle_in = e; ci = i; cw = w; cs = s; indata = d;
        model();
        @(posedge clk);
        #1;
        check("outdata", 32'(outdata), 32'(e_data));
        check("outelecidle", 32'(outelecidle), 32'(e_eidle));
        check("txcomfinish", 32'(fin), 32'(e_fin));
        @(negedge clk);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_outdata", 32'(outdata), 32'h0);
        check("rst_outelecidle", 32'(outelecidle), 32'h1);
        check("rst_txcomfinish", 32'(fin), 32'h0);
        act = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("init_outdata", 32'(outdata), 32'h0);
        check("init_outelecidle", 32'(outelecidle), 32'h1);
        check("init_txcomfinish", 32'(fin), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 20'hABCDE);
        cyc(0, 0, 0, 0, 20'h12345);
        cyc(1, 0, 1, 0, 20'($urandom));
        repeat (100) cyc(1, 0, 0, 0, 20'($urandom));
        cyc(1, 1, 0, 1, 20'($urandom));
        repeat (200) cyc(1, 0, 0, 0, 20'($urandom));
        cyc(1, 0, 0, 1, 20'($urandom));
        repeat (100) cyc(1, 0, ($urandom % 4) == 0, 0, 20'($urandom));
        cyc(0, 0, 0, 0, 20'($urandom));
        repeat (3) cyc(0, 0, 0, 0, 20'($urandom));
        cyc(0, 1, 0, 0, 20'($urandom));
        repeat (3) cyc(0, 0, 0, 0, 20'($urandom));
        cyc(1, 0, 1, 0, 20'($urandom));
        repeat (34) cyc(1, 0, 0, 0, 20'($urandom));
        reset_mid();
        repeat (3) cyc(1, 0, 0, 0, 20'($urandom));
        repeat (220) cyc(1, 0, 1, 0, 20'(($urandom)));
        repeat (3000) begin
            if (($urandom % 1500) == 0) reset_mid();
            cyc(($urandom % 400) != 0, ($urandom % 30) == 0, ($urandom % 30) == 0,
                ($urandom % 30) == 0, 20'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
